seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Scan sequencer for the 4-digit 7-segment display path.
- Generates the 2-bit digit-select that drives the display sync/mux stage, plus a per-digit blanking strobe for ghost suppression.
- Holds the displayed hex, point and LE words in frame-synchronous registers: host writes go through a request/ack handshake and only take effect at a frame boundary, so digits never tear mid-frame.

Parameters:
- SLOT_CYC, 100000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 1000: cycles at the start of each slot with blank asserted; must be < SLOT_CYC.
- CNT_W, 17: width of the slot counter; must satisfy 2^CNT_W ≥ SLOT_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  hold the slot counter and scan index
- wr_req  in  1  host write request (level or pulse)
- wr_hexs  in  16  hex nibbles to display; digit 0 = [3:0]
- wr_point  in  4  decimal-point bits, one per digit
- wr_les  in  4  LE bits, one per digit
- wr_ack  out  1  one-cycle pulse when pending data committed
- scan  out  2  digit index, to the sync/mux Scan input
- blank  out  1  1 = force all anodes off this cycle
- frame_tick  out  1  one-cycle pulse on the last cycle of digit 3
- hexs_o  out  16  committed hex word
- point_o  out  4  committed point word
- les_o  out  4  committed LE word
- pending  out  1  write accepted, not yet committed

Behaviour:
- Reset is async on rst_n low. Reset values: slot_cnt=0, scan=0, blank=1, frame_tick=0, wr_ack=0, pending=0, hexs_o=0, point_o=4'hF, les_o=4'h0, pending buffers=0.
- slot_cnt counts 0..SLOT_CYC-1 and wraps to 0. At the wrap edge scan increments modulo 4 (3 → 0).
- blank is registered: it is 1 exactly while slot_cnt < BLANK_CYC. Every slot therefore starts with BLANK_CYC blanked cycles followed by SLOT_CYC-BLANK_CYC lit cycles. scan changes only inside a blanked window.
- frame_tick is combinational: (slot_cnt == SLOT_CYC-1) and (scan == 3).
- freeze=1:
  - slot_cnt and scan hold; blank holds its current value; frame_tick is forced 0.
  - Writes may still be accepted into the buffers.
  - No commit happens while frozen.
- Write acceptance: any cycle with wr_req=1 copies wr_hexs, wr_point and wr_les into the pending buffers and sets pending=1. Repeated requests before a commit overwrite the buffers (last write wins) and produce a single ack.
- Commit:
  - Occurs on the edge where frame_tick=1 and pending=1 held before that edge.
  - That edge loads hexs_o/point_o/les_o from the buffers and clears pending.
  - wr_ack=1 in the following cycle, for exactly one cycle.
- Simultaneous wr_req and commit edge: the commit uses the buffer contents from before the edge. The new request reloads the buffers and leaves pending=1, so it is committed at the next frame boundary.
- Outputs hexs_o/point_o/les_o change only at commit edges or at reset.
- Reset asserted mid-slot or mid-handshake discards pending data with no ack; scanning restarts at scan=0 with blank=1.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask[3:0] and parameter BLINK_FRAMES (default 256).
  - An internal frame counter counts 0..BLINK_FRAMES-1 on frame_tick.
  - While the counter is in its upper half (≥ BLINK_FRAMES/2) and blink_mask[scan]=1, blank is forced to 1 for the whole slot.
  - The counter resets to 0 on rst_n and holds during freeze.
- Undefined: no blink_mask port, no frame counter; blank follows the slot-counter rule only.

Test Plan (SLOT_CYC=8, BLANK_CYC=2):
- Release reset, freeze=0 → scan steps 0,1,2,3,0 every 8 cycles. blank=1 for the first 2 cycles of each slot. frame_tick pulses once every 32 cycles, on the last cycle with scan=3.
- Mid-frame at scan=1, single-cycle wr_req with wr_hexs=16'h1234, wr_point=4'hE, wr_les=4'h5 → pending=1, hexs_o stays 0. After the next frame_tick edge: hexs_o=16'h1234, point_o=4'hE, les_o=4'h5, pending=0, wr_ack pulses 1 cycle.
- Two writes in one frame (16'hAAAA, then 16'hBBBB) → single ack; hexs_o=16'hBBBB.
- wr_req=16'hCCCC in the same cycle as frame_tick with older 16'h1111 pending → 16'h1111 committed now; 16'hCCCC committed at the next frame with a second ack.
- freeze=1 for 20 cycles at scan=2, slot_cnt=5 → scan and slot_cnt hold, no frame_tick, no commit. Resume continues from slot_cnt=5.
- rst_n low mid-slot with pending=1 → all outputs return to reset values immediately; no wr_ack afterwards.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: digit scan sequencer for the 4-digit 7-segment display.
// Produces the digit select (scan), the per-slot ghost-suppression blank, a
// frame tick, and frame-synchronous copies of the host hex/point/LE words.
// Optional build macro SEG_SCAN_BLINK_EN adds blink_mask and a frame counter
// that blanks masked digits during the upper half of each blink period.
module seg_scan_ctrl #(
  parameter int SLOT_CYC     = 100000,
  parameter int BLANK_CYC    = 1000,
  parameter int CNT_W        = 17
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 256
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        wr_req,
  input  logic [15:0] wr_hexs,
  input  logic [3:0]  wr_point,
  input  logic [3:0]  wr_les,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [3:0]  blink_mask,
`endif
  output logic        wr_ack,
  output logic [1:0]  scan,
  output logic        blank,
  output logic        frame_tick,
  output logic [15:0] hexs_o,
  output logic [3:0]  point_o,
  output logic [3:0]  les_o,
  output logic        pending
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] slot_nxt;
  logic [1:0]       scan_nxt;
  logic             blank_nxt;
  logic             blink_nxt;
  logic             slot_wrap;
  logic             commit;
  logic [15:0]      hexs_buf;
  logic [3:0]       point_buf;
  logic [3:0]       les_buf;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_tick = !freeze && slot_wrap && (scan == 2'd3);
  // A commit needs data that was already pending before this edge.
  assign commit     = frame_tick && pending;

`ifdef SEG_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [FC_W-1:0] FC_HALF = FC_W'(BLINK_FRAMES / 2);

  logic [FC_W-1:0] frame_cnt;
  logic [FC_W-1:0] frame_nxt;

  // Next blink-period position; advances once per frame, frozen with the scan.
  always_comb begin
    frame_nxt = frame_cnt;
    if (frame_tick) begin
      frame_nxt = (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
    end
  end

  // Blink period frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else        frame_cnt <= frame_nxt;
  end

  // Blink is evaluated against the slot being entered so it covers the whole slot.
  assign blink_nxt = (frame_nxt >= FC_HALF) && blink_mask[scan_nxt];
`else
  assign blink_nxt = 1'b0;
`endif

  // Next slot position and blank level; blank is registered from the next count
  // so it lines up exactly with slot_cnt < BLANK_CYC.
  always_comb begin
    slot_nxt  = slot_cnt;
    scan_nxt  = scan;
    blank_nxt = blank;
    if (!freeze) begin
      if (slot_wrap) begin
        slot_nxt = '0;
        scan_nxt = scan + 2'd1;
      end else begin
        slot_nxt = slot_cnt + CNT_W'(1);
      end
      blank_nxt = (slot_nxt < BLANK_LIM) || blink_nxt;
    end
  end

  // Slot counter, digit index and blank register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      scan     <= 2'd0;
      blank    <= 1'b1;
    end else begin
      slot_cnt <= slot_nxt;
      scan     <= scan_nxt;
      blank    <= blank_nxt;
    end
  end

  // Host write buffers; a new request always wins over a simultaneous commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hexs_buf  <= 16'h0000;
      point_buf <= 4'h0;
      les_buf   <= 4'h0;
      pending   <= 1'b0;
    end else begin
      if (wr_req) begin
        hexs_buf  <= wr_hexs;
        point_buf <= wr_point;
        les_buf   <= wr_les;
      end
      pending <= wr_req || (pending && !commit);
    end
  end

  // Displayed words only change at a frame boundary; ack follows the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hexs_o  <= 16'h0000;
      point_o <= 4'hF;
      les_o   <= 4'h0;
      wr_ack  <= 1'b0;
    end else begin
      if (commit) begin
        hexs_o  <= hexs_buf;
        point_o <= point_buf;
        les_o   <= les_buf;
      end
      wr_ack <= commit;
    end
  end

endmodule
